ras_ckpt_ctrl: RTL and testbench
================================

RAS_CKPT_CTRL -- requirements
Module: ras_ckpt_ctrl

Interface
REQ-001 Parameter N_CKPT, default 8, SHALL set the number of in-flight RAS checkpoints (power of two, >=2).
REQ-002 Parameter TOS_W, default 4, SHALL set the RAS top-of-stack pointer width.
REQ-003 Parameter PC_W, default 32, SHALL set the saved return-address width; ID_W = log2(N_CKPT).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 alloc_req_i  in  1  fetch requests a checkpoint for a call/return/branch.
REQ-007 alloc_tos_i  in  TOS_W  speculative TOS to save.
REQ-008 alloc_top_i  in  PC_W  RAS top-entry value to save.
REQ-009 alloc_gnt_o  out  1  combinational grant for this cycle's request.
REQ-010 alloc_id_o  out  ID_W  slot index granted (equals tail pointer).
REQ-011 commit_i  in  1  oldest checkpoint retires in order.
REQ-012 recover_i  in  1  misprediction; restore from recover_id_i.
REQ-013 recover_id_i  in  ID_W  checkpoint to restore.
REQ-014 flush_i  in  1  exception; discard all checkpoints.
REQ-015 restore_valid_o  out  1  registered pulse; restore_tos_o/restore_top_o valid.
REQ-016 restore_tos_o  out  TOS_W; restore_top_o  out  PC_W  restored values.
REQ-017 full_o, empty_o  out  1 each; count_o  out  ID_W+1  occupancy.
REQ-018 err_o  out  1  registered pulse on an illegal commit or recover.

Function
REQ-019 Storage SHALL be a circular buffer of N_CKPT entries {valid, tos, top} with head (oldest), tail (next free) and count registers.
REQ-020 alloc_gnt_o SHALL equal alloc_req_i & ~full_o & ~recover_i & ~flush_i.
REQ-021 On grant, entry[tail] SHALL be written {1, alloc_tos_i, alloc_top_i}; tail and count SHALL advance by 1 at the next edge.
REQ-022 A commit with count>0 SHALL clear entry[head].valid and advance head; a commit with count==0 SHALL be ignored and pulse err_o next cycle.
REQ-023 Alloc and commit in the same cycle SHALL leave count unchanged and move both pointers.
REQ-024 Recover with entry[recover_id_i].valid SHALL, at the next edge: drive restore_valid_o=1 with that entry's tos/top; set tail=recover_id_i; clear valid of recover_id_i and all younger entries up to old tail; count=(recover_id_i-head) mod N_CKPT.
REQ-025 Recover to an invalid entry SHALL change no state and pulse err_o.
REQ-026 Commit during a valid recover SHALL also apply when recover_id_i!=head (count reduced by 1 further, head advanced); when recover_id_i==head, commit SHALL be ignored and err_o pulsed.
REQ-027 Priority SHALL be flush_i > recover_i > {commit_i, alloc}; flush SHALL clear all valid bits, set head=tail=0, count=0, with no restore_valid_o pulse.
REQ-028 Pointers SHALL wrap modulo N_CKPT; full_o=(count==N_CKPT), empty_o=(count==0), both combinational from count.
REQ-029 restore_valid_o and err_o SHALL be single-cycle pulses; restore data SHALL hold its last value otherwise.

Reset
REQ-030 Reset SHALL force head=tail=count=0, all valid=0, restore_valid_o=0, restore_tos_o=0, restore_top_o=0, err_o=0, asynchronously and mid-operation.
REQ-031 After reset deassertion, empty_o=1, full_o=0, and alloc_gnt_o SHALL follow alloc_req_i in the first cycle.

Verification
REQ-032 Fill: 8 allocs (tos 1..8) -> ids 0..7, full_o=1, count_o=8; 9th request -> alloc_gnt_o=0.
REQ-033 Recover: 5 allocs (tos 3,4,5,6,7, top 0x100..0x104), recover_id=2 -> next cycle restore_valid_o=1, tos=5, top=0x102, count_o=2, next alloc_id_o=2.
REQ-034 Wrap: alloc 6, commit 6, alloc 4 -> ids 6,7,0,1; count_o=4; commit order head 6,7,0,1.
REQ-035 Simultaneous: count=3, head=0, recover_id=2 with commit -> count_o=1, head=1; recover_id=0 with commit -> err_o pulse, count_o=0.
REQ-036 Flush with recover and alloc pending at count=5 -> count_o=0, no restore pulse, alloc_gnt_o=0 that cycle; commit on empty -> err_o.
REQ-037 Reset asserted asynchronously mid-recover -> all outputs 0 and empty_o=1 before the next clock edge.

Source files
------------

// File: rtl/ras_ckpt_ctrl_if.sv
// Bundle of alloc/commit/recover/flush handshakes and status for the RAS checkpoint controller.
// The slave modport is the controller side; master is the fetch/backend driver side.
interface ras_ckpt_ctrl_if #(
  parameter int N_CKPT = 8,
  parameter int TOS_W  = 4,
  parameter int PC_W   = 32
);
  localparam int ID_W = $clog2(N_CKPT);

  logic             alloc_req_i;
  logic [TOS_W-1:0] alloc_tos_i;
  logic [PC_W-1:0]  alloc_top_i;
  logic             alloc_gnt_o;
  logic [ID_W-1:0]  alloc_id_o;
  logic             commit_i;
  logic             recover_i;
  logic [ID_W-1:0]  recover_id_i;
  logic             flush_i;
  logic             restore_valid_o;
  logic [TOS_W-1:0] restore_tos_o;
  logic [PC_W-1:0]  restore_top_o;
  logic             full_o;
  logic             empty_o;
  logic [ID_W:0]    count_o;
  logic             err_o;

  modport slave (
    input  alloc_req_i, alloc_tos_i, alloc_top_i, commit_i, recover_i, recover_id_i, flush_i,
    output alloc_gnt_o, alloc_id_o, restore_valid_o, restore_tos_o, restore_top_o,
           full_o, empty_o, count_o, err_o
  );

  modport master (
    output alloc_req_i, alloc_tos_i, alloc_top_i, commit_i, recover_i, recover_id_i, flush_i,
    input  alloc_gnt_o, alloc_id_o, restore_valid_o, restore_tos_o, restore_top_o,
           full_o, empty_o, count_o, err_o
  );
endinterface

// File: rtl/ras_ckpt_ctrl.sv
// Circular buffer of RAS checkpoints: allocated at fetch, retired in order by commit,
// rolled back to a chosen slot on misprediction and discarded wholesale on flush.
module ras_ckpt_ctrl #(
  parameter int N_CKPT = 8,
  parameter int TOS_W  = 4,
  parameter int PC_W   = 32
) (
  input logic            clk,
  input logic            reset,
  ras_ckpt_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(N_CKPT);

  logic [N_CKPT-1:0] valid_q, valid_d;
  logic [TOS_W-1:0]  tos_q [N_CKPT];
  logic [PC_W-1:0]   top_q [N_CKPT];
  logic [ID_W-1:0]   head_q, head_d;
  logic [ID_W-1:0]   tail_q, tail_d;
  logic [ID_W:0]     count_q, count_d;
  logic              restoreValid_q, restoreValid_d;
  logic [TOS_W-1:0]  restoreTos_q, restoreTos_d;
  logic [PC_W-1:0]   restoreTop_q, restoreTop_d;
  logic              err_q, err_d;

  logic              full;
  logic              allocGnt;
  logic              recoverOk;
  logic              commitOk;
  logic [ID_W-1:0]   recOff;
  logic [ID_W-1:0]   slotOff [N_CKPT];

  assign full      = (count_q == (ID_W+1)'(N_CKPT));
  assign allocGnt  = bus.alloc_req_i & ~full & ~bus.recover_i & ~bus.flush_i;
  assign recoverOk = bus.recover_i & valid_q[bus.recover_id_i];
  assign commitOk  = bus.commit_i & (count_q != '0);
  assign recOff    = bus.recover_id_i - head_q;

  // Age of each slot relative to head; slots at or beyond the recover point are squashed.
  for (genvar g = 0; g < N_CKPT; g++) begin : g_off
    assign slotOff[g] = ID_W'(g) - head_q;
  end

  always_comb begin
    valid_d        = valid_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    restoreValid_d = 1'b0;
    restoreTos_d   = restoreTos_q;
    restoreTop_d   = restoreTop_q;
    err_d          = 1'b0;
    if (bus.flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bus.recover_i) begin
      if (recoverOk) begin
        restoreValid_d = 1'b1;
        restoreTos_d   = tos_q[bus.recover_id_i];
        restoreTop_d   = top_q[bus.recover_id_i];
        tail_d         = bus.recover_id_i;
        count_d        = {1'b0, recOff};
        for (int i = 0; i < N_CKPT; i++) begin
          if (slotOff[i] >= recOff) valid_d[i] = 1'b0;
        end
        // A commit alongside a rollback to the head would retire the restored slot itself.
        if (bus.commit_i) begin
          if (recOff != '0) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            count_d         = {1'b0, recOff} - (ID_W+1)'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      if (commitOk) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end else if (bus.commit_i) begin
        err_d = 1'b1;
      end
      if (allocGnt) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + (ID_W+1)'(allocGnt) - (ID_W+1)'(commitOk);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      restoreValid_q <= 1'b0;
      restoreTos_q   <= '0;
      restoreTop_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      restoreValid_q <= restoreValid_d;
      restoreTos_q   <= restoreTos_d;
      restoreTop_q   <= restoreTop_d;
      err_q          <= err_d;
    end
  end

  // Payload storage needs no reset: it is only read through a set valid bit.
  always_ff @(posedge clk) begin
    if (allocGnt) begin
      tos_q[tail_q] <= bus.alloc_tos_i;
      top_q[tail_q] <= bus.alloc_top_i;
    end
  end

  assign bus.alloc_gnt_o     = allocGnt;
  assign bus.alloc_id_o      = tail_q;
  assign bus.full_o          = full;
  assign bus.empty_o         = (count_q == '0);
  assign bus.count_o         = count_q;
  assign bus.restore_valid_o = restoreValid_q;
  assign bus.restore_tos_o   = restoreTos_q;
  assign bus.restore_top_o   = restoreTop_q;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Bench for ras_ckpt_ctrl: table of hand-computed vectors, directed corner sequences and
// random traffic, all compared against a queue-based model of the checkpoint list.
module tb_ras_ckpt_ctrl;
  localparam int N = 8;

  typedef struct {
    int          id;
    logic [3:0]  tos;
    logic [31:0] top;
  } ent_t;

  typedef struct {
    logic        req;
    logic [3:0]  tos;
    logic [31:0] top;
    logic        cmt;
    logic        rec;
    logic [2:0]  rid;
    logic        fl;
    logic        eGnt;
    logic [2:0]  eId;
    logic [3:0]  eCnt;
    logic        eRv;
    logic        eErr;
    logic [3:0]  eRTos;
    logic [31:0] eRTop;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  ras_ckpt_ctrl_if #(.N_CKPT(N), .TOS_W(4), .PC_W(32)) bus();

  ras_ckpt_ctrl #(.N_CKPT(N), .TOS_W(4), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  ent_t        mq[$];
  int          mHead;
  logic        expRv;
  logic        expErr;
  logic [3:0]  expTos;
  logic [31:0] expTop;
  logic        sampGnt;
  logic [2:0]  sampId;
  logic [3:0]  sampCnt;
  vec_t        vecs[12];

  logic        rReq, rCmt, rRec, rFl, rInQ;
  logic [2:0]  rRid;
  logic [3:0]  rTos;
  logic [31:0] rTop;

  // One comparison; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mHead  = 0;
    expRv  = 1'b0;
    expErr = 1'b0;
    expTos = '0;
    expTop = '0;
  endtask

  // Drive one cycle of inputs, check combinational outputs before the edge and
  // registered outputs after it, advancing the reference list in between.
  task automatic applyStimulus(input logic req, input logic [3:0] tos, input logic [31:0] top,
                               input logic cmt, input logic rec, input logic [2:0] rid,
                               input logic fl);
    int   k;
    int   preSize;
    int   preId;
    logic preGnt;
    bus.alloc_req_i  = req;
    bus.alloc_tos_i  = tos;
    bus.alloc_top_i  = top;
    bus.commit_i     = cmt;
    bus.recover_i    = rec;
    bus.recover_id_i = rid;
    bus.flush_i      = fl;
    preSize = mq.size();
    preId   = (mHead + preSize) % N;
    preGnt  = req && (preSize < N) && !rec && !fl;
    @(negedge clk);
    sampGnt = bus.alloc_gnt_o;
    sampId  = bus.alloc_id_o;
    sampCnt = bus.count_o;
    checkOutput("alloc_gnt", 64'(sampGnt), 64'(preGnt));
    checkOutput("alloc_id", 64'(sampId), 64'(preId));
    checkOutput("count_pre", 64'(sampCnt), 64'(preSize));
    checkOutput("full", 64'(bus.full_o), 64'(preSize == N));
    checkOutput("empty", 64'(bus.empty_o), 64'(preSize == 0));
    @(posedge clk);
    #1;
    expRv  = 1'b0;
    expErr = 1'b0;
    if (fl) begin
      mq.delete();
      mHead = 0;
    end else if (rec) begin
      k = -1;
      foreach (mq[j]) if (mq[j].id == int'(rid)) k = j;
      if (k < 0) begin
        expErr = 1'b1;
      end else begin
        expRv  = 1'b1;
        expTos = mq[k].tos;
        expTop = mq[k].top;
        while (mq.size() > k) void'(mq.pop_back());
        if (cmt) begin
          if (k > 0) begin
            void'(mq.pop_front());
            mHead = (mHead + 1) % N;
          end else begin
            expErr = 1'b1;
          end
        end
      end
    end else begin
      if (cmt) begin
        if (preSize > 0) begin
          void'(mq.pop_front());
          mHead = (mHead + 1) % N;
        end else begin
          expErr = 1'b1;
        end
      end
      if (preGnt) mq.push_back('{preId, tos, top});
    end
    checkOutput("restore_valid", 64'(bus.restore_valid_o), 64'(expRv));
    checkOutput("err", 64'(bus.err_o), 64'(expErr));
    checkOutput("restore_tos", 64'(bus.restore_tos_o), 64'(expTos));
    checkOutput("restore_top", 64'(bus.restore_top_o), 64'(expTop));
    checkOutput("count_post", 64'(bus.count_o), 64'(mq.size()));
  endtask

  task automatic idleInputs();
    bus.alloc_req_i  = 1'b0;
    bus.alloc_tos_i  = '0;
    bus.alloc_top_i  = '0;
    bus.commit_i     = 1'b0;
    bus.recover_i    = 1'b0;
    bus.recover_id_i = '0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idleInputs();
    modelReset();
    #12;
    checkOutput("reset_count", 64'(bus.count_o), 64'(0));
    checkOutput("reset_empty", 64'(bus.empty_o), 64'(1));
    checkOutput("reset_full", 64'(bus.full_o), 64'(0));
    checkOutput("reset_rv", 64'(bus.restore_valid_o), 64'(0));
    checkOutput("reset_err", 64'(bus.err_o), 64'(0));
    checkOutput("reset_id", 64'(bus.alloc_id_o), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Five allocations, rollback to slot 2, then head-collision, empty-commit and stale-recover errors.
    vecs[0]  = '{1, 3, 'h100, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 4, 'h101, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};
    vecs[2]  = '{1, 5, 'h102, 0, 0, 0, 0,  1, 2, 2, 0, 0, 0, 0};
    vecs[3]  = '{1, 6, 'h103, 0, 0, 0, 0,  1, 3, 3, 0, 0, 0, 0};
    vecs[4]  = '{1, 7, 'h104, 0, 0, 0, 0,  1, 4, 4, 0, 0, 0, 0};
    vecs[5]  = '{1, 8, 'h1ff, 0, 1, 2, 0,  0, 5, 5, 1, 0, 5, 'h102};
    vecs[6]  = '{1, 9, 'h200, 0, 0, 0, 0,  1, 2, 2, 0, 0, 5, 'h102};
    vecs[7]  = '{0, 0, 0,     1, 0, 0, 0,  0, 3, 3, 0, 0, 5, 'h102};
    vecs[8]  = '{0, 0, 0,     1, 1, 1, 0,  0, 3, 2, 1, 1, 4, 'h101};
    vecs[9]  = '{0, 0, 0,     1, 0, 0, 0,  0, 1, 0, 0, 1, 4, 'h101};
    vecs[10] = '{0, 0, 0,     0, 1, 5, 0,  0, 1, 0, 0, 1, 4, 'h101};
    vecs[11] = '{0, 0, 0,     0, 0, 0, 0,  0, 1, 0, 0, 0, 4, 'h101};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req, vecs[i].tos, vecs[i].top, vecs[i].cmt,
                    vecs[i].rec, vecs[i].rid, vecs[i].fl);
      checkOutput($sformatf("vec%0d_gnt", i), 64'(sampGnt), 64'(vecs[i].eGnt));
      checkOutput($sformatf("vec%0d_id", i), 64'(sampId), 64'(vecs[i].eId));
      checkOutput($sformatf("vec%0d_cnt", i), 64'(sampCnt), 64'(vecs[i].eCnt));
      checkOutput($sformatf("vec%0d_rv", i), 64'(bus.restore_valid_o), 64'(vecs[i].eRv));
      checkOutput($sformatf("vec%0d_err", i), 64'(bus.err_o), 64'(vecs[i].eErr));
      checkOutput($sformatf("vec%0d_rtos", i), 64'(bus.restore_tos_o), 64'(vecs[i].eRTos));
      checkOutput($sformatf("vec%0d_rtop", i), 64'(bus.restore_top_o), 64'(vecs[i].eRTop));
    end

    // Fill to capacity, then a ninth request must be refused.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 4'(i + 1), 32'h300 + 32'(i), 0, 0, 0, 0);
      checkOutput("fill_id", 64'(sampId), 64'(i));
    end
    checkOutput("fill_full", 64'(bus.full_o), 64'(1));
    checkOutput("fill_count", 64'(bus.count_o), 64'(8));
    applyStimulus(1, 4'hf, 32'h3ff, 0, 0, 0, 0);
    checkOutput("fill_ninth_gnt", 64'(sampGnt), 64'(0));

    // Flush beats a pending recover and alloc at occupancy 5; commit on empty then errors.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("flush_pre_count", 64'(bus.count_o), 64'(5));
    applyStimulus(1, 4'h2, 32'h400, 0, 1, 3'd5, 1);
    checkOutput("flush_gnt", 64'(sampGnt), 64'(0));
    checkOutput("flush_count", 64'(bus.count_o), 64'(0));
    checkOutput("flush_rv", 64'(bus.restore_valid_o), 64'(0));
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("empty_commit_err", 64'(bus.err_o), 64'(1));

    // Pointer wrap: six in, six out, four more land in slots 6,7,0,1.
    for (int i = 0; i < 6; i++) applyStimulus(1, 4'(i), 32'h500 + 32'(i), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'(10 + i), 32'h600 + 32'(i), 0, 0, 0, 0);
      checkOutput("wrap_id", 64'(sampId), 64'((6 + i) % 8));
    end
    checkOutput("wrap_count", 64'(bus.count_o), 64'(4));
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd0, 0);
    checkOutput("wrap_restore_tos", 64'(bus.restore_tos_o), 64'(12));
    checkOutput("wrap_restore_count", 64'(bus.count_o), 64'(1));

    // Recover plus commit: behind the head retires one more; at the head it is an error.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'(i + 1), 32'h700 + 32'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 3'd2, 0);
    checkOutput("rc_count", 64'(bus.count_o), 64'(1));
    checkOutput("rc_err", 64'(bus.err_o), 64'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rc_next_id", 64'(sampId), 64'(2));
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'(i + 4), 32'h800 + 32'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 3'd0, 0);
    checkOutput("rc_head_err", 64'(bus.err_o), 64'(1));
    checkOutput("rc_head_count", 64'(bus.count_o), 64'(0));

    // Asynchronous reset landing while a restore pulse is on the outputs.
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'(i + 7), 32'h900 + 32'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd1, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_rv", 64'(bus.restore_valid_o), 64'(0));
    checkOutput("areset_tos", 64'(bus.restore_tos_o), 64'(0));
    checkOutput("areset_top", 64'(bus.restore_top_o), 64'(0));
    checkOutput("areset_err", 64'(bus.err_o), 64'(0));
    checkOutput("areset_count", 64'(bus.count_o), 64'(0));
    checkOutput("areset_empty", 64'(bus.empty_o), 64'(1));
    checkOutput("areset_full", 64'(bus.full_o), 64'(0));
    checkOutput("areset_id", 64'(bus.alloc_id_o), 64'(0));
    checkOutput("areset_gnt", 64'(bus.alloc_gnt_o), 64'(0));
    idleInputs();
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 4'h3, 32'ha00, 0, 0, 0, 0);
    checkOutput("post_reset_gnt", 64'(sampGnt), 64'(1));

    // Random traffic; commits are withheld when a recover targets a slot not in flight.
    for (int c = 0; c < 600; c++) begin
      rReq = ($urandom_range(0, 9) < 6);
      rCmt = ($urandom_range(0, 9) < 3);
      rRec = ($urandom_range(0, 9) == 0);
      rFl  = ($urandom_range(0, 49) == 0);
      rTos = 4'($urandom);
      rTop = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 9) < 7)
        rRid = 3'(mq[$urandom_range(0, mq.size() - 1)].id);
      else
        rRid = 3'($urandom_range(0, 7));
      rInQ = 1'b0;
      foreach (mq[j]) if (mq[j].id == int'(rRid)) rInQ = 1'b1;
      if (rRec && !rInQ) rCmt = 1'b0;
      applyStimulus(rReq, rTos, rTop, rCmt, rRec, rRid, rFl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
